// File: rtl/qupls_decode_sequencer_pkg.sv
// Shared types for the decode sequencer: queue entry layout, FSM states and
// the micro-op count clamp.
package qupls_decode_sequencer_pkg;

    typedef logic [31:0] ex_instruction_t;

    typedef struct packed {
        ex_instruction_t ins;
        logic [1:0]      pcnt;
        logic [2:0]      ucnt;
    } dec_qent_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_MACRO
    } seq_state_t;

    localparam int WIN_N = 6;

    function automatic logic [2:0] clamp_ucnt(input logic [2:0] u, input int maxu);
        return (int'(u) > maxu) ? 3'(maxu) : u;
    endfunction

endpackage

// File: rtl/qupls_decode_queue.sv
// Circular instruction buffer with single push, 1-4 entry pop and a
// six-entry read window starting at the head.
module qupls_decode_queue
    import qupls_decode_sequencer_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int AW     = $clog2(QDEPTH),
    parameter int CW     = AW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  dec_qent_t                   push_ent,
    input  logic                        pop,
    input  logic [2:0]                  popn,
    output logic [CW-1:0]               count,
    output logic [1:0]                  head_pcnt,
    output logic [2:0]                  head_ucnt,
    output ex_instruction_t [WIN_N-1:0] win
);

    dec_qent_t       q [QDEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;

    // Pointers and occupancy are control state; the storage itself is never reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(popn);
            count <= count + CW'(push) - (pop ? CW'(popn) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            q[tail] <= push_ent;
    end

    always_comb begin
        win       = '0;
        head_pcnt = '0;
        head_ucnt = '0;
        if (count != '0) begin
            head_pcnt = q[head].pcnt;
            head_ucnt = q[head].ucnt;
        end
        for (int k = 0; k < WIN_N; k++) begin
            if (k < int'(count))
                win[k] = q[head + AW'(k)].ins;
        end
    end

endmodule

// File: rtl/qupls_decode_sequencer.sv
// Feeds the decoder from the aligned-instruction queue, steps macro
// instructions through their micro-ops and handshakes with rename.
module qupls_decode_sequencer
    import qupls_decode_sequencer_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int MAXU   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        fet_v,
    output logic                        fet_rdy,
    input  ex_instruction_t             fet_ins,
    input  logic [1:0]                  fet_pcnt,
    input  logic [2:0]                  fet_ucnt,
    output ex_instruction_t [WIN_N-1:0] dec_win,
    output logic                        dec_en,
    output logic [2:0]                  dec_step,
    output logic                        dec_v,
    input  logic                        ren_rdy,
    output logic                        busy
);

    localparam int CW = $clog2(QDEPTH) + 1;

    seq_state_t                  state, state_nx;
    logic [2:0]                  step, step_nx;
    logic [CW-1:0]               count;
    logic [1:0]                  head_pcnt;
    logic [2:0]                  head_ucnt;
    logic [2:0]                  ucnt_lim;
    logic [2:0]                  popn;
    logic                        pop;
    logic                        push;
    logic                        dispatchable;
    ex_instruction_t [WIN_N-1:0] qwin;

    qupls_decode_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_ent  ('{ins: fet_ins, pcnt: fet_pcnt, ucnt: fet_ucnt}),
        .pop       (pop),
        .popn      (popn),
        .count     (count),
        .head_pcnt (head_pcnt),
        .head_ucnt (head_ucnt),
        .win       (qwin)
    );

    assign ucnt_lim = clamp_ucnt(head_ucnt, MAXU);
    assign popn     = {1'b0, head_pcnt} + 3'd1;

    // The head only dispatches once every postfix word behind it has arrived.
    assign dispatchable = (count >= CW'(popn)) && (!dec_v || ren_rdy);
    assign dec_en       = dispatchable && !flush && !rst;
    assign fet_rdy      = !rst && !flush && ((count < CW'(QDEPTH)) || pop);
    assign push         = fet_v && fet_rdy;

    always_comb begin
        state_nx = state;
        step_nx  = step;
        pop      = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (dec_en) begin
                    if (ucnt_lim == 3'd0) begin
                        pop = 1'b1;
                    end else begin
                        step_nx  = 3'd1;
                        state_nx = SEQ_MACRO;
                    end
                end
            end
            SEQ_MACRO: begin
                if (dec_en) begin
                    if (step < ucnt_lim) begin
                        step_nx = step + 3'd1;
                    end else begin
                        pop      = 1'b1;
                        step_nx  = 3'd0;
                        state_nx = SEQ_IDLE;
                    end
                end
            end
            default: state_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= SEQ_IDLE;
            step  <= 3'd0;
            dec_v <= 1'b0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            dec_v <= dec_en ? 1'b1 : (ren_rdy ? 1'b0 : dec_v);
        end
    end

    assign dec_win  = rst ? '0 : qwin;
    assign dec_step = step;
    assign busy     = (count != '0) || dec_v || (state == SEQ_MACRO);

endmodule

// File: doc/qupls_decode_sequencer.md
Name: qupls_decode_sequencer

Overview:
- Sits between the fetch/align stage and the instruction decoder. It buffers aligned instructions and presents a 6-entry window (head plus following entries, which supply postfix immediates) to the decoder.
- Drives the decoder enable and sequences macro instructions through multiple micro-op steps.
- Manages the valid/ready handshake toward rename, and flushes on branch miss or exception.

Parameters:
- QDEPTH, 8, instruction queue entries; power of two, must be >= 8.
- MAXU, 7, maximum micro-op step index for a macro instruction.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all buffered and in-flight decode state
- fet_v  in  1  fetch entry valid
- fet_rdy  out  1  sequencer can accept an entry this cycle
- fet_ins  in  $bits(ex_instruction_t)  aligned instruction
- fet_pcnt  in  2  number of postfix words following this instruction (0-3), predecoded by fetch
- fet_ucnt  in  3  last micro-op step index (0 = not a macro)
- dec_win  out  6 x ex_instruction_t  decoder instruction window; entry 0 is the head
- dec_en  out  1  decoder enable; decoder captures dec_win at the next clk
- dec_step  out  3  micro-op step index for the current dispatch
- dec_v  out  1  decoder output register holds a valid instruction
- ren_rdy  in  1  rename accepts the decoder output this cycle
- busy  out  1  queue non-empty, or dec_v, or a macro is in progress

Behaviour:
- Reset: synchronous, active-high, on rst; clock clk.
  - head=0, tail=0, count=0, step=0, dec_v=0.
  - fet_rdy=0 during the rst cycle.
  - dec_en=0, dec_step=0, busy=0, dec_win all zero.
- Queue:
  - Circular buffer; entry = {ins, pcnt, ucnt}.
  - Push on fet_v&&fet_rdy.
  - fet_rdy = !rst && !flush && (count < QDEPTH || pop_this_cycle). Pop frees space in the same cycle.
  - count' = count + push - popn.
  - head and tail wrap modulo QDEPTH.
- Window:
  - dec_win[k] = q[(head+k) mod QDEPTH] when k < count, else zero.
  - Combinational from queue state.
- Dispatchable when both hold:
  - count >= 1 + q[head].pcnt, i.e. the head and all its postfixes are present.
  - dec_v==0 || ren_rdy.
- dec_en = dispatchable && !flush && !rst.
- dec_step = step register. dec_en is the only decoder enable.
- Micro-op sequencing, state IDLE/MACRO:
  - IDLE:
    - On dec_en with ucnt==0: pop 1+pcnt entries, stay IDLE.
    - On dec_en with ucnt>0: no pop, step becomes 1, go to MACRO.
  - MACRO, per dec_en:
    - If step < ucnt: step+1, no pop.
    - If step == ucnt: pop 1+pcnt entries, step=0, go IDLE.
  - Stalls (dec_en=0) hold step.
  - ucnt above MAXU is clamped to MAXU.
- Output handshake:
  - dec_v' = dec_en ? 1 : (ren_rdy ? 0 : dec_v).
  - Decoder latency is one cycle: the instruction presented with dec_en is valid on the cycle dec_v rises.
  - Back-to-back dispatch sustains one instruction or micro-op per cycle while ren_rdy=1.
- Simultaneous push and pop are both performed. A push into the slot freed by the same-cycle pop is legal when count==QDEPTH.
- Flush, taking priority over everything except rst:
  - Next cycle: count=0, head=tail=0, step=0, state IDLE, dec_v=0.
  - No push is accepted and no dec_en is asserted in the flush cycle.
  - A flush mid-macro abandons the remaining steps.
- Postfix incomplete at head (count < 1+pcnt): hold; dec_en=0, with no partial dispatch.
- busy = (count!=0) || dec_v || (state==MACRO).

Decomposition:
- QuplsPkg additions:
  - typedef dec_qent_t {ex_instruction_t ins; logic [1:0] pcnt; logic [2:0] ucnt;}.
  - typedef enum seq_state_t {SEQ_IDLE, SEQ_MACRO}.
- One sub-module: qupls_decode_queue.
  - Circular buffer with push, variable pop count (1-4), count output and 6-entry window read.
  - The sequencer FSM and handshake stay in the top.

Test Plan:
1. Reset, then push 3 plain instructions (pcnt=0, ucnt=0) with ren_rdy=1 -> dec_en on 3 consecutive cycles; dec_v high cycles 2-4 after the first push accepted; count returns to 0; busy falls.
2. Push an instruction with pcnt=2, then its postfixes with a 2-cycle gap between them -> dec_en stays 0 until the third word is present; dispatch pops 3; dec_win[1..2] carry the postfixes.
3. Macro with ucnt=3, ren_rdy=1 -> dec_en four cycles with dec_step 0,1,2,3; head pops only after step 3; the following instruction dispatches on the next cycle.
4. Fill the queue to QDEPTH=8 with ren_rdy=0 -> fet_rdy=0 at count 8. Raise ren_rdy -> pop and push in the same cycle; count stays 8.
5. flush asserted on step 1 of a ucnt=4 macro with 5 entries queued -> next cycle count=0, dec_v=0, step=0, fet_rdy=1; the next push dispatches normally with dec_step=0.
6. Drive tail across the wrap (e.g. 20 single pushes/pops) -> dec_win ordering is correct at head=6,7,0,1; no entries are lost or duplicated.
